// File: rtl/fml_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fml_arbiter                                                  |
// | Description : Two-master FML arbiter with read-tag FIFO for data return.   |
// |               `FML_ARB_FIXED_PRIO_EN selects fixed priority (master 0).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef FML_ADR_RNG
`define FML_ADR_RNG 25:0
`endif
`ifndef FML_DAT_RNG
`define FML_DAT_RNG 63:0
`endif
`ifndef FML_BE_RNG
`define FML_BE_RNG 7:0
`endif

module fml_arbiter #(
  parameter int burst_len = 4,
  parameter int tag_depth = 8
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [`FML_ADR_RNG] m0_adr,
  input  logic               m0_rd,
  input  logic               m0_wr,
  input  logic [`FML_DAT_RNG] m0_wdat,
  input  logic [`FML_BE_RNG]  m0_wbe,
  input  logic               m0_wnext,
  input  logic               m0_rnext,
  output logic               m0_done,
  output logic               m0_rempty,
  output logic [`FML_DAT_RNG] m0_rdat,

  input  logic [`FML_ADR_RNG] m1_adr,
  input  logic               m1_rd,
  input  logic               m1_wr,
  input  logic [`FML_DAT_RNG] m1_wdat,
  input  logic [`FML_BE_RNG]  m1_wbe,
  input  logic               m1_wnext,
  input  logic               m1_rnext,
  output logic               m1_done,
  output logic               m1_rempty,
  output logic [`FML_DAT_RNG] m1_rdat,

  output logic [`FML_ADR_RNG] fml_adr,
  output logic               fml_rd,
  output logic               fml_wr,
  output logic [`FML_DAT_RNG] fml_wdat,
  output logic [`FML_BE_RNG]  fml_wbe,
  output logic               fml_wnext,
  output logic               fml_rnext,
  input  logic               fml_done,
  input  logic               fml_rempty,
  input  logic [`FML_DAT_RNG] fml_rdat
);

  localparam int               c_PTR_W   = (tag_depth > 1) ? $clog2(tag_depth) : 1;
  localparam logic [c_PTR_W:0] c_DEPTH   = tag_depth[c_PTR_W:0];
  localparam logic [c_PTR_W:0] c_CNT_ONE = 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [3:0]       c_BURST   = burst_len[3:0];
  localparam logic [3:0]       c_ONE4    = 4'd1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CMD   = 2'd1;
  localparam logic [1:0] c_ST_WDATA = 2'd2;

  logic [1:0]         r_state;
  logic               r_gnt;
  logic [3:0]         r_beat;
  logic [3:0]         r_burst;
  logic               r_tag_mem [tag_depth];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic w_full, w_empty, w_elig0, w_elig1, w_pick;
  logic w_in_cmd, w_in_wr, w_head, w_push, w_pop;
  logic w_g_rd, w_g_wr, w_g_wnext, w_h_rnext;
  logic [3:0] w_beat_next;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // A read can only be granted while a tag slot is free for its return burst.
  assign w_elig0 = m0_wr | (m0_rd & ~w_full);
  assign w_elig1 = m1_wr | (m1_rd & ~w_full);

`ifdef FML_ARB_FIXED_PRIO_EN
  assign w_pick = ~w_elig0;
`else
  logic r_prio;
  assign w_pick = (w_elig0 & w_elig1) ? r_prio : w_elig1;
`endif

  assign w_in_cmd  = (r_state == c_ST_CMD);
  assign w_in_wr   = (r_state == c_ST_CMD) | (r_state == c_ST_WDATA);
  assign w_g_rd    = r_gnt ? m1_rd    : m0_rd;
  assign w_g_wr    = r_gnt ? m1_wr    : m0_wr;
  assign w_g_wnext = r_gnt ? m1_wnext : m0_wnext;

  assign fml_adr   = r_gnt ? m1_adr : m0_adr;
  assign fml_rd    = w_in_cmd & w_g_rd;
  assign fml_wr    = w_in_cmd & w_g_wr;
  assign fml_wdat  = w_in_wr ? (r_gnt ? m1_wdat : m0_wdat) : '0;
  assign fml_wbe   = w_in_wr ? (r_gnt ? m1_wbe  : m0_wbe)  : '0;
  assign fml_wnext = w_in_wr & w_g_wnext;

  assign m0_done = fml_done & w_in_cmd & ~r_gnt;
  assign m1_done = fml_done & w_in_cmd &  r_gnt;

  // Head tag steers the returning burst; the other master sees an empty FIFO.
  assign w_head    = r_tag_mem[r_rd_ptr];
  assign m0_rempty = w_empty |  w_head | fml_rempty;
  assign m1_rempty = w_empty | ~w_head | fml_rempty;
  assign w_h_rnext = w_head ? m1_rnext : m0_rnext;
  assign fml_rnext = ~w_empty & w_h_rnext & ~fml_rempty;
  assign m0_rdat   = fml_rdat;
  assign m1_rdat   = fml_rdat;

  assign w_beat_next = r_beat + {3'b000, fml_wnext};
  assign w_push      = w_in_cmd & fml_done & w_g_rd;
  assign w_pop       = fml_rnext & (r_burst == (c_BURST - c_ONE4));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_gnt   <= 1'b0;
      r_beat  <= 4'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_gnt   <= w_pick;
            r_beat  <= 4'd0;
            r_state <= c_ST_CMD;
          end
        end
        c_ST_CMD: begin
          r_beat <= w_beat_next;
          if (fml_done) begin
            if (w_g_rd || (w_beat_next >= c_BURST))
              r_state <= c_ST_IDLE;
            else
              r_state <= c_ST_WDATA;
          end
        end
        c_ST_WDATA: begin
          r_beat <= w_beat_next;
          if (w_beat_next >= c_BURST)
            r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifndef FML_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)
      r_prio <= 1'b0;
    else if ((r_state == c_ST_IDLE) && (w_elig0 | w_elig1))
      r_prio <= ~w_pick;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push)
      r_tag_mem[r_wr_ptr] <= r_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_burst  <= 4'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (fml_rnext)
        r_burst <= w_pop ? 4'd0 : (r_burst + c_ONE4);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fml_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fml_arbiter                                               |
// | Description : Randomized bench for fml_arbiter against a behavioural model.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef FML_ADR_RNG
`define FML_ADR_RNG 25:0
`endif
`ifndef FML_DAT_RNG
`define FML_DAT_RNG 63:0
`endif
`ifndef FML_BE_RNG
`define FML_BE_RNG 7:0
`endif

module tb_fml_arbiter;

  localparam int BL = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]          rd_i, wr_i, wnext_i, rnext_i;
  logic [`FML_ADR_RNG] adr_i  [2];
  logic [`FML_DAT_RNG] wdat_i [2];
  logic [`FML_BE_RNG]  wbe_i  [2];

  logic m0_rd, m0_wr, m0_wnext, m0_rnext, m1_rd, m1_wr, m1_wnext, m1_rnext;
  logic [`FML_ADR_RNG] m0_adr, m1_adr, fml_adr;
  logic [`FML_DAT_RNG] m0_wdat, m1_wdat, m0_rdat, m1_rdat, fml_wdat, fml_rdat;
  logic [`FML_BE_RNG]  m0_wbe, m1_wbe, fml_wbe;
  logic m0_done, m1_done, m0_rempty, m1_rempty;
  logic fml_rd, fml_wr, fml_wnext, fml_rnext, fml_done, fml_rempty;

  assign m0_rd = rd_i[0];       assign m1_rd = rd_i[1];
  assign m0_wr = wr_i[0];       assign m1_wr = wr_i[1];
  assign m0_wnext = wnext_i[0]; assign m1_wnext = wnext_i[1];
  assign m0_rnext = rnext_i[0]; assign m1_rnext = rnext_i[1];
  assign m0_adr = adr_i[0];     assign m1_adr = adr_i[1];
  assign m0_wdat = wdat_i[0];   assign m1_wdat = wdat_i[1];
  assign m0_wbe = wbe_i[0];     assign m1_wbe = wbe_i[1];

  fml_arbiter #(.burst_len(BL), .tag_depth(TD)) dut (
    .clk(clk), .reset(reset),
    .m0_adr(m0_adr), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_wdat(m0_wdat),
    .m0_wbe(m0_wbe), .m0_wnext(m0_wnext), .m0_rnext(m0_rnext),
    .m0_done(m0_done), .m0_rempty(m0_rempty), .m0_rdat(m0_rdat),
    .m1_adr(m1_adr), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_wdat(m1_wdat),
    .m1_wbe(m1_wbe), .m1_wnext(m1_wnext), .m1_rnext(m1_rnext),
    .m1_done(m1_done), .m1_rempty(m1_rempty), .m1_rdat(m1_rdat),
    .fml_adr(fml_adr), .fml_rd(fml_rd), .fml_wr(fml_wr), .fml_wdat(fml_wdat),
    .fml_wbe(fml_wbe), .fml_wnext(fml_wnext), .fml_rnext(fml_rnext),
    .fml_done(fml_done), .fml_rempty(fml_rempty), .fml_rdat(fml_rdat)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase 0 = waiting for a request, 1 = command issued,
  // 2 = draining remaining write beats. Tags are a plain queue of master ids.
  int ph;
  bit g;
  bit fav;
  int beats;
  int words;
  int q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rnext();
    if (q.size() == 0) return 1'b0;
    return rnext_i[q[0]] && !fml_rempty;
  endfunction

  task automatic check_outputs();
    bit in_cmd, in_w;
    logic [1:0] exp_re;
    in_cmd = (ph == 1);
    in_w   = (ph == 1) || (ph == 2);
    chk("fml_rd", 64'(fml_rd), 64'(in_cmd && rd_i[g]));
    chk("fml_wr", 64'(fml_wr), 64'(in_cmd && wr_i[g]));
    if (in_cmd) chk("fml_adr", 64'(fml_adr), 64'(adr_i[g]));
    chk("fml_wnext", 64'(fml_wnext), 64'(in_w && wnext_i[g]));
    chk("fml_wdat", 64'(fml_wdat), in_w ? 64'(wdat_i[g]) : 64'd0);
    chk("fml_wbe", 64'(fml_wbe), in_w ? 64'(wbe_i[g]) : 64'd0);
    chk("m0_done", 64'(m0_done), 64'(fml_done && in_cmd && (g == 1'b0)));
    chk("m1_done", 64'(m1_done), 64'(fml_done && in_cmd && (g == 1'b1)));
    exp_re = 2'b11;
    if (q.size() != 0) exp_re[q[0]] = fml_rempty;
    chk("m0_rempty", 64'(m0_rempty), 64'(exp_re[0]));
    chk("m1_rempty", 64'(m1_rempty), 64'(exp_re[1]));
    chk("fml_rnext", 64'(fml_rnext), 64'(exp_rnext()));
    chk("m0_rdat", 64'(m0_rdat), 64'(fml_rdat));
    chk("m1_rdat", 64'(m1_rdat), 64'(fml_rdat));
  endtask

  task automatic model_reset();
    ph = 0; g = 1'b0; fav = 1'b0; beats = 0; words = 0;
    q.delete();
  endtask

  task automatic advance();
    bit e0, e1, pick, wn, rn, push;
    e0   = wr_i[0] || (rd_i[0] && (q.size() < TD));
    e1   = wr_i[1] || (rd_i[1] && (q.size() < TD));
    wn   = (ph != 0) && wnext_i[g];
    rn   = exp_rnext();
    push = (ph == 1) && fml_done && rd_i[g];
    if (rn) begin
      words++;
      if (words == BL) begin
        words = 0;
        void'(q.pop_front());
      end
    end
    if (push) q.push_back(int'(g));
    case (ph)
      0: if (e0 || e1) begin
`ifdef FML_ARB_FIXED_PRIO_EN
        pick = !e0;
`else
        pick = (e0 && e1) ? fav : e1;
        fav  = !pick;
`endif
        g = pick; ph = 1; beats = 0;
      end
      1: begin
        beats += int'(wn);
        if (fml_done) ph = (rd_i[g] || beats >= BL) ? 0 : 2;
      end
      default: begin
        beats += int'(wn);
        if (beats >= BL) ph = 0;
      end
    endcase
  endtask

  // One clock cycle: drive protocol-respecting random inputs, check, advance.
  task automatic step(input int p_req, input int p_rnext, input bit rst);
    reset = rst;
    for (int n = 0; n < 2; n++) begin
      if (!(ph != 0 && int'(g) == n)) begin
        if ($urandom_range(99) < p_req) begin
          wr_i[n] = 1'($urandom_range(1));
          rd_i[n] = !wr_i[n];
        end else begin
          wr_i[n] = 1'b0;
          rd_i[n] = 1'b0;
        end
        adr_i[n] = 26'($urandom);
      end
      wdat_i[n] = {$urandom, $urandom};
      wbe_i[n]  = 8'($urandom);
      if (ph != 0 && int'(g) == n)
        wnext_i[n] = (beats < BL) ? 1'($urandom_range(1)) : 1'b0;
      else
        wnext_i[n] = 1'($urandom_range(1));
      rnext_i[n] = ($urandom_range(99) < p_rnext);
    end
    fml_done   = ($urandom_range(99) < 35);
    fml_rempty = ($urandom_range(99) < 25);
    fml_rdat   = {$urandom, $urandom};
    #2;
    check_outputs();
    if (rst) model_reset();
    else     advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rd_i = '0; wr_i = '0; wnext_i = '0; rnext_i = '0;
    for (int n = 0; n < 2; n++) begin
      adr_i[n] = '0; wdat_i[n] = '0; wbe_i[n] = '0;
    end
    fml_done = 1'b0; fml_rempty = 1'b1; fml_rdat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (4)    step(0, 0, 1'b0);
    repeat (300)  step(60, 0, 1'b0);
    repeat (1500) step(50, 60, 1'b0);
    repeat (1500) step(70, 40, ($urandom_range(199) == 0));
    repeat (3)    step(0, 0, 1'b1);
    repeat (4)    step(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
